mem_arbiter: RTL and testbench

Single-port memory arbiter and byte sequencer between the core's three memory clients and the byte-wide RAM/IO bus. Clients are the instruction fetcher (4-byte reads), the load/store buffer (1/2/4-byte loads) and the reorder buffer (committed 1/2/4-byte stores and IO reads). It grants one request at a time by fixed priority and splits each access into per-byte bus cycles. It reassembles read data little-endian and aborts speculative reads on a misprediction flush.

---
 rtl/mem_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Memory arbiter and byte sequencer: grants one of fetch / load-store buffer /
// reorder buffer by fixed priority and walks the access one byte per cycle over
// the byte-wide RAM/IO bus, reassembling read data little-endian.
module mem_arbiter #(
  parameter logic [1:0] IO_SEL = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_done,
  output logic [31:0] fetch_data,
  input  logic        lsb_req,
  input  logic [31:0] lsb_addr,
  input  logic [2:0]  lsb_size,
  output logic        lsb_done,
  output logic [31:0] lsb_data,
  input  logic        rob_req,
  input  logic        rob_wr,
  input  logic [31:0] rob_addr,
  input  logic [2:0]  rob_size,
  input  logic [31:0] rob_wdata,
  output logic        rob_done,
  output logic [31:0] rob_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  localparam logic [1:0] OWN_FETCH = 2'd0;
  localparam logic [1:0] OWN_LSB   = 2'd1;
  localparam logic [1:0] OWN_ROB   = 2'd2;

  // Byte count from the size field: the highest set bit wins.
  function automatic logic [2:0] size_bytes(input logic [2:0] size);
    if (size[2])      return 3'd4;
    else if (size[1]) return 3'd2;
    else              return 3'd1;
  endfunction

  state_t      state_q, state_n;
  logic [1:0]  owner_q, owner_n;
  logic [31:0] addr_q, addr_n;
  logic [31:0] wdata_q, wdata_n;
  logic [31:0] buf_q, buf_n;
  logic [2:0]  cnt_q, cnt_n;
  logic [2:0]  iss_q, iss_n;
  logic [2:0]  cap_q, cap_n;
  logic [2:0]  rd_iss;
  logic        cap_en_q, cap_en_n;
  logic        held_q, held_n;
  logic        io_stall;
  logic        grant;
  logic        fetch_done_n, lsb_done_n, rob_done_n;
  logic [31:0] fetch_data_n, lsb_data_n, rob_rdata_n;

  // Next-state, bus drive and completion logic.
  always_comb begin
    state_n      = state_q;
    owner_n      = owner_q;
    addr_n       = addr_q;
    wdata_n      = wdata_q;
    buf_n        = buf_q;
    cnt_n        = cnt_q;
    iss_n        = iss_q;
    cap_n        = cap_q;
    cap_en_n     = cap_en_q;
    held_n       = held_q;
    grant        = 1'b0;
    fetch_done_n = fetch_done;
    lsb_done_n   = lsb_done;
    rob_done_n   = rob_done;
    fetch_data_n = fetch_data;
    lsb_data_n   = lsb_data;
    rob_rdata_n  = rob_rdata;
    mem_a        = 32'd0;
    mem_wr       = 1'b0;
    mem_dout     = 8'd0;

    // After a freeze, read bytes whose data was lost are re-issued from the
    // capture pointer; the bus holds its last value while frozen.
    rd_iss   = (held_q && rdy) ? cap_q : iss_q;
    io_stall = (addr_q[17:16] == IO_SEL) && io_buffer_full;

    case (state_q)
      READ: begin
        if (rd_iss < cnt_q) mem_a = addr_q + {29'd0, rd_iss};
      end
      WRITE: begin
        if (!io_stall) begin
          mem_a    = addr_q + {29'd0, iss_q};
          mem_dout = wdata_q[{iss_q[1:0], 3'b000} +: 8];
          mem_wr   = rdy;
        end
      end
      default: ;
    endcase

    if (rdy) begin
      held_n       = 1'b0;
      fetch_done_n = 1'b0;
      lsb_done_n   = 1'b0;
      rob_done_n   = 1'b0;
      case (state_q)
        IDLE: begin
          grant = 1'b1;
          if (rob_req && !rob_done) begin
            owner_n = OWN_ROB;
            addr_n  = rob_addr;
            cnt_n   = size_bytes(rob_size);
            wdata_n = rob_wdata;
            state_n = rob_wr ? WRITE : READ;
          end else if (!flush && lsb_req && !lsb_done) begin
            owner_n = OWN_LSB;
            addr_n  = lsb_addr;
            cnt_n   = size_bytes(lsb_size);
            wdata_n = 32'd0;
            state_n = READ;
          end else if (!flush && fetch_req && !fetch_done) begin
            owner_n = OWN_FETCH;
            addr_n  = fetch_addr;
            cnt_n   = 3'd4;
            wdata_n = 32'd0;
            state_n = READ;
          end else begin
            grant = 1'b0;
          end
          if (grant) begin
            iss_n    = 3'd0;
            cap_n    = 3'd0;
            cap_en_n = 1'b0;
            buf_n    = 32'd0;
          end
        end
        READ: begin
          if (rd_iss < cnt_q) begin
            iss_n    = rd_iss + 3'd1;
            cap_en_n = 1'b1;
          end else begin
            iss_n    = rd_iss;
            cap_en_n = 1'b0;
          end
          // mem_din belongs to the address issued on the previous active cycle.
          if (cap_en_q && !held_q && (cap_q < cnt_q)) begin
            buf_n[{cap_q[1:0], 3'b000} +: 8] = mem_din;
            cap_n = cap_q + 3'd1;
          end
          if (flush && (owner_q != OWN_ROB)) begin
            state_n = IDLE;
          end else if (cap_n == cnt_q) begin
            state_n = IDLE;
            case (owner_q)
              OWN_FETCH: begin fetch_done_n = 1'b1; fetch_data_n = buf_n; end
              OWN_LSB:   begin lsb_done_n   = 1'b1; lsb_data_n   = buf_n; end
              default:   begin rob_done_n   = 1'b1; rob_rdata_n  = buf_n; end
            endcase
          end
        end
        WRITE: begin
          if (!io_stall) begin
            iss_n = iss_q + 3'd1;
            if (iss_n == cnt_q) begin
              state_n    = IDLE;
              rob_done_n = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end else begin
      held_n = 1'b1;
    end
  end

  // State, pointer and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_FETCH;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      buf_q      <= 32'd0;
      cnt_q      <= 3'd0;
      iss_q      <= 3'd0;
      cap_q      <= 3'd0;
      cap_en_q   <= 1'b0;
      held_q     <= 1'b0;
      fetch_done <= 1'b0;
      lsb_done   <= 1'b0;
      rob_done   <= 1'b0;
      fetch_data <= 32'd0;
      lsb_data   <= 32'd0;
      rob_rdata  <= 32'd0;
    end else begin
      state_q    <= state_n;
      owner_q    <= owner_n;
      addr_q     <= addr_n;
      wdata_q    <= wdata_n;
      buf_q      <= buf_n;
      cnt_q      <= cnt_n;
      iss_q      <= iss_n;
      cap_q      <= cap_n;
      cap_en_q   <= cap_en_n;
      held_q     <= held_n;
      fetch_done <= fetch_done_n;
      lsb_done   <= lsb_done_n;
      rob_done   <= rob_done_n;
      fetch_data <= fetch_data_n;
      lsb_data   <= lsb_data_n;
      rob_rdata  <= rob_rdata_n;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter: per-cycle bus checks plus queues of expected
// write bytes and read results that are consumed as the DUT produces them.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic        fetch_req, fetch_done;
  logic [31:0] fetch_addr, fetch_data;
  logic        lsb_req, lsb_done;
  logic [31:0] lsb_addr, lsb_data;
  logic [2:0]  lsb_size;
  logic        rob_req, rob_wr, rob_done;
  logic [31:0] rob_addr, rob_wdata, rob_rdata;
  logic [2:0]  rob_size;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;

  typedef struct packed { logic [31:0] a; logic [7:0] d; } wbyte_t;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_data_q[$];
  wbyte_t      exp_wr_q[$];
  logic [7:0]  ram [0:131071];

  always #5 clk = ~clk;

  // Synchronous RAM: read byte appears the cycle after its address.
  always @(posedge clk) mem_din <= ram[mem_a[16:0]];

  mem_arbiter #(.IO_SEL(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_done(fetch_done), .fetch_data(fetch_data),
    .lsb_req(lsb_req), .lsb_addr(lsb_addr), .lsb_size(lsb_size), .lsb_done(lsb_done), .lsb_data(lsb_data),
    .rob_req(rob_req), .rob_wr(rob_wr), .rob_addr(rob_addr), .rob_size(rob_size), .rob_wdata(rob_wdata),
    .rob_done(rob_done), .rob_rdata(rob_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
    fetch_req = 1'b0; fetch_addr = 32'd0;
    lsb_req = 1'b0; lsb_addr = 32'd0; lsb_size = 3'd0;
    rob_req = 1'b0; rob_wr = 1'b0; rob_addr = 32'd0; rob_size = 3'd0; rob_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    total++;
    if ({mem_a, mem_wr, mem_dout} !== 41'd0)
      begin bad++; $display("FAIL reset_bus got a=%h wr=%b dout=%h want 0", mem_a, mem_wr, mem_dout); end
    total++;
    if ({fetch_done, lsb_done, rob_done} !== 3'b000)
      begin bad++; $display("FAIL reset_done got=%b want=000", {fetch_done, lsb_done, rob_done}); end
    total++;
    if ({fetch_data, lsb_data, rob_rdata} !== 96'd0)
      begin bad++; $display("FAIL reset_data got=%h %h %h want 0", fetch_data, lsb_data, rob_rdata); end
    nxt();
    rst = 1'b1;
  endtask

  task automatic test_fetch();
    logic [31:0] exp_a;
    ram[17'h1000] = 8'h13; ram[17'h1001] = 8'h05; ram[17'h1002] = 8'h00; ram[17'h1003] = 8'h00;
    for (int c = 0; c < 9; c++) begin
      if (c == 0) begin fetch_addr = 32'h1000; fetch_req = 1'b1; exp_data_q.push_back(32'h0000_0513); end
      if (c == 7) fetch_req = 1'b0;
      @(negedge clk);
      exp_a = (c >= 1 && c <= 4) ? 32'h1000 + 32'(c - 1) : 32'd0;
      total++;
      if (mem_a !== exp_a || mem_wr !== 1'b0)
        begin bad++; $display("FAIL fetch_bus c=%0d got a=%h wr=%b want a=%h wr=0", c, mem_a, mem_wr, exp_a); end
      total++;
      if (fetch_done !== (c == 6))
        begin bad++; $display("FAIL fetch_done c=%0d got=%b want=%b", c, fetch_done, (c == 6)); end
      if (fetch_done === 1'b1 && exp_data_q.size() > 0) begin
        exp_a = exp_data_q.pop_front();
        total++;
        if (fetch_data !== exp_a) begin bad++; $display("FAIL fetch_data got=%h want=%h", fetch_data, exp_a); end
      end
      nxt();
    end
    total++;
    if (exp_data_q.size() != 0) begin bad++; $display("FAIL fetch_pending got=%0d want=0", exp_data_q.size()); exp_data_q.delete(); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_a;
    wbyte_t      w;
    ram[17'h300] = 8'h34; ram[17'h301] = 8'h12;
    for (int c = 0; c < 12; c++) begin
      if (c == 0) begin
        rob_req = 1'b1; rob_wr = 1'b1; rob_addr = 32'h200; rob_size = 3'b100; rob_wdata = 32'hAABB_CCDD;
        lsb_req = 1'b1; lsb_addr = 32'h300; lsb_size = 3'b010;
        exp_wr_q.push_back({32'h200, 8'hDD}); exp_wr_q.push_back({32'h201, 8'hCC});
        exp_wr_q.push_back({32'h202, 8'hBB}); exp_wr_q.push_back({32'h203, 8'hAA});
        exp_data_q.push_back(32'h0000_1234);
      end
      if (c == 6) rob_req = 1'b0;
      if (c == 10) lsb_req = 1'b0;
      @(negedge clk);
      total++;
      if (mem_wr !== (c >= 1 && c <= 4))
        begin bad++; $display("FAIL b2b_wr c=%0d got=%b want=%b", c, mem_wr, (c >= 1 && c <= 4)); end
      if (mem_wr === 1'b1) begin
        total++;
        if (exp_wr_q.size() == 0) begin bad++; $display("FAIL b2b_extra_write c=%0d got a=%h want none", c, mem_a); end
        else begin
          w = exp_wr_q.pop_front();
          if (mem_a !== w.a || mem_dout !== w.d)
            begin bad++; $display("FAIL b2b_byte c=%0d got %h:%h want %h:%h", c, mem_a, mem_dout, w.a, w.d); end
        end
      end
      if (c >= 5 && c <= 8) begin
        exp_a = (c == 6) ? 32'h300 : (c == 7) ? 32'h301 : 32'd0;
        total++;
        if (mem_a !== exp_a) begin bad++; $display("FAIL b2b_rd_addr c=%0d got=%h want=%h", c, mem_a, exp_a); end
      end
      total++;
      if (rob_done !== (c == 5) || lsb_done !== (c == 9))
        begin bad++; $display("FAIL b2b_done c=%0d got rob=%b lsb=%b", c, rob_done, lsb_done); end
      if (lsb_done === 1'b1 && exp_data_q.size() > 0) begin
        exp_a = exp_data_q.pop_front();
        total++;
        if (lsb_data !== exp_a) begin bad++; $display("FAIL b2b_lsb_data got=%h want=%h", lsb_data, exp_a); end
      end
      nxt();
    end
    total++;
    if (exp_wr_q.size() != 0 || exp_data_q.size() != 0)
      begin bad++; $display("FAIL b2b_pending got=%0d/%0d want=0/0", exp_wr_q.size(), exp_data_q.size()); exp_wr_q.delete(); exp_data_q.delete(); end
  endtask

  task automatic test_flush();
    logic [31:0] exp_a;
    for (int c = 0; c < 13; c++) begin
      if (c == 0) begin
        lsb_req = 1'b1; lsb_addr = 32'h300; lsb_size = 3'b010;
        fetch_req = 1'b1; fetch_addr = 32'h1000; exp_data_q.push_back(32'h0000_0513);
      end
      if (c == 2) begin flush = 1'b1; lsb_req = 1'b0; end
      if (c == 4) flush = 1'b0;
      if (c == 11) fetch_req = 1'b0;
      @(negedge clk);
      exp_a = (c == 1) ? 32'h300 : (c == 2) ? 32'h301 :
              (c >= 5 && c <= 8) ? 32'h1000 + 32'(c - 5) : 32'd0;
      total++;
      if (mem_a !== exp_a) begin bad++; $display("FAIL flush_addr c=%0d got=%h want=%h", c, mem_a, exp_a); end
      total++;
      if (lsb_done !== 1'b0 || fetch_done !== (c == 10))
        begin bad++; $display("FAIL flush_done c=%0d got lsb=%b fetch=%b", c, lsb_done, fetch_done); end
      if (fetch_done === 1'b1 && exp_data_q.size() > 0) begin
        exp_a = exp_data_q.pop_front();
        total++;
        if (fetch_data !== exp_a) begin bad++; $display("FAIL flush_fetch_data got=%h want=%h", fetch_data, exp_a); end
      end
      nxt();
    end
    total++;
    if (exp_data_q.size() != 0) begin bad++; $display("FAIL flush_pending got=%0d want=0", exp_data_q.size()); exp_data_q.delete(); end
  endtask

  task automatic test_io_stall();
    wbyte_t w;
    for (int c = 0; c < 8; c++) begin
      if (c == 0) begin
        rob_req = 1'b1; rob_wr = 1'b1; rob_addr = 32'h0003_0000; rob_size = 3'b001; rob_wdata = 32'hFFFF_FF41;
        exp_wr_q.push_back({32'h0003_0000, 8'h41});
      end
      if (c == 1) io_buffer_full = 1'b1;
      if (c == 4) io_buffer_full = 1'b0;
      if (c == 6) rob_req = 1'b0;
      @(negedge clk);
      total++;
      if (mem_wr !== (c == 4)) begin bad++; $display("FAIL io_wr c=%0d got=%b want=%b", c, mem_wr, (c == 4)); end
      if (c >= 1 && c <= 3) begin
        total++;
        if (mem_a !== 32'd0) begin bad++; $display("FAIL io_stall_addr c=%0d got=%h want=0", c, mem_a); end
      end
      if (mem_wr === 1'b1 && exp_wr_q.size() > 0) begin
        w = exp_wr_q.pop_front();
        total++;
        if (mem_a !== w.a || mem_dout !== w.d)
          begin bad++; $display("FAIL io_byte got %h:%h want %h:%h", mem_a, mem_dout, w.a, w.d); end
      end
      total++;
      if (rob_done !== (c == 5)) begin bad++; $display("FAIL io_done c=%0d got=%b want=%b", c, rob_done, (c == 5)); end
      nxt();
    end
    total++;
    if (exp_wr_q.size() != 0) begin bad++; $display("FAIL io_pending got=%0d want=0", exp_wr_q.size()); exp_wr_q.delete(); end
  endtask

  task automatic test_io_read();
    logic [31:0] exp_a;
    ram[17'h10004] = 8'h5A; ram[17'h10005] = 8'hA5;
    io_buffer_full = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c == 0) begin
        rob_req = 1'b1; rob_wr = 1'b0; rob_addr = 32'h0003_0004; rob_size = 3'b011;
        exp_data_q.push_back(32'h0000_A55A);
      end
      if (c == 5) rob_req = 1'b0;
      @(negedge clk);
      exp_a = (c == 1) ? 32'h0003_0004 : (c == 2) ? 32'h0003_0005 : 32'd0;
      total++;
      if (mem_a !== exp_a || mem_wr !== 1'b0)
        begin bad++; $display("FAIL ioread_bus c=%0d got a=%h wr=%b want a=%h wr=0", c, mem_a, mem_wr, exp_a); end
      total++;
      if (rob_done !== (c == 4)) begin bad++; $display("FAIL ioread_done c=%0d got=%b want=%b", c, rob_done, (c == 4)); end
      if (rob_done === 1'b1 && exp_data_q.size() > 0) begin
        exp_a = exp_data_q.pop_front();
        total++;
        if (rob_rdata !== exp_a) begin bad++; $display("FAIL ioread_data got=%h want=%h", rob_rdata, exp_a); end
      end
      nxt();
    end
    io_buffer_full = 1'b0;
    total++;
    if (exp_data_q.size() != 0) begin bad++; $display("FAIL ioread_pending got=%0d want=0", exp_data_q.size()); exp_data_q.delete(); end
  endtask

  task automatic test_rdy_freeze();
    logic [31:0] exp_a;
    int          ndone;
    logic        drop;
    ram[17'h0] = 8'h11; ram[17'h1] = 8'h22; ram[17'h2] = 8'h33; ram[17'h3] = 8'h44;
    ndone = 0;
    drop  = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (c == 0) begin fetch_addr = 32'h0; fetch_req = 1'b1; exp_data_q.push_back(32'h4433_2211); end
      if (c == 3) rdy = 1'b0;
      if (c == 4) rdy = 1'b1;
      if (drop) fetch_req = 1'b0;
      @(negedge clk);
      if (c == 1 || c == 2 || c == 4) begin
        exp_a = (c == 2) ? 32'h1 : (c == 4) ? 32'h1 : 32'h0;
        total++;
        if (mem_a !== exp_a) begin bad++; $display("FAIL rdy_addr c=%0d got=%h want=%h", c, mem_a, exp_a); end
      end
      if (c == 3) begin
        total++;
        if (mem_wr !== 1'b0 || fetch_done !== 1'b0)
          begin bad++; $display("FAIL rdy_frozen got wr=%b done=%b want 0/0", mem_wr, fetch_done); end
      end
      if (c <= 6) begin
        total++;
        if (fetch_done !== 1'b0) begin bad++; $display("FAIL rdy_early_done c=%0d got=%b want=0", c, fetch_done); end
      end
      if (fetch_done === 1'b1) begin
        ndone++;
        drop = 1'b1;
        if (exp_data_q.size() > 0) begin
          exp_a = exp_data_q.pop_front();
          total++;
          if (fetch_data !== exp_a) begin bad++; $display("FAIL rdy_data got=%h want=%h", fetch_data, exp_a); end
        end
      end
      nxt();
    end
    fetch_req = 1'b0;
    total++;
    if (ndone != 1) begin bad++; $display("FAIL rdy_done_count got=%0d want=1", ndone); end
    exp_data_q.delete();
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a;
    ram[17'h1FFFE] = 8'hEF; ram[17'h1FFFF] = 8'hBE; ram[17'h0] = 8'hAD; ram[17'h1] = 8'hDE;
    for (int c = 0; c < 8; c++) begin
      if (c == 0) begin
        lsb_req = 1'b1; lsb_addr = 32'hFFFF_FFFE; lsb_size = 3'b100;
        exp_data_q.push_back(32'hDEAD_BEEF);
      end
      if (c == 7) lsb_req = 1'b0;
      @(negedge clk);
      exp_a = (c >= 1 && c <= 4) ? 32'hFFFF_FFFE + 32'(c - 1) : 32'd0;
      total++;
      if (mem_a !== exp_a) begin bad++; $display("FAIL wrap_addr c=%0d got=%h want=%h", c, mem_a, exp_a); end
      total++;
      if (lsb_done !== (c == 6)) begin bad++; $display("FAIL wrap_done c=%0d got=%b want=%b", c, lsb_done, (c == 6)); end
      if (lsb_done === 1'b1 && exp_data_q.size() > 0) begin
        exp_a = exp_data_q.pop_front();
        total++;
        if (lsb_data !== exp_a) begin bad++; $display("FAIL wrap_data got=%h want=%h", lsb_data, exp_a); end
      end
      nxt();
    end
    total++;
    if (exp_data_q.size() != 0) begin bad++; $display("FAIL wrap_pending got=%0d want=0", exp_data_q.size()); exp_data_q.delete(); end
  endtask

  task automatic test_reset_midstore();
    wbyte_t w;
    for (int c = 0; c < 9; c++) begin
      if (c == 0) begin
        rob_req = 1'b1; rob_wr = 1'b1; rob_addr = 32'h400; rob_size = 3'b100; rob_wdata = 32'h0102_0304;
        exp_wr_q.push_back({32'h400, 8'h04}); exp_wr_q.push_back({32'h401, 8'h03});
      end
      if (c == 2) begin rst = 1'b0; rob_req = 1'b0; end
      if (c == 4) rst = 1'b1;
      @(negedge clk);
      total++;
      if (mem_wr !== (c == 1 || c == 2))
        begin bad++; $display("FAIL rstw_wr c=%0d got=%b want=%b", c, mem_wr, (c == 1 || c == 2)); end
      if (mem_wr === 1'b1 && exp_wr_q.size() > 0) begin
        w = exp_wr_q.pop_front();
        total++;
        if (mem_a !== w.a || mem_dout !== w.d)
          begin bad++; $display("FAIL rstw_byte got %h:%h want %h:%h", mem_a, mem_dout, w.a, w.d); end
      end
      total++;
      if (rob_done !== 1'b0) begin bad++; $display("FAIL rstw_done c=%0d got=%b want=0", c, rob_done); end
      if (c == 3) begin
        total++;
        if ({mem_a, mem_dout, fetch_done, lsb_done, fetch_data, lsb_data, rob_rdata} !== 138'd0)
          begin bad++; $display("FAIL rstw_outputs got a=%h d=%h fd=%h ld=%h rd=%h want 0", mem_a, mem_dout, fetch_data, lsb_data, rob_rdata); end
      end
      nxt();
    end
    total++;
    if (exp_wr_q.size() != 0) begin bad++; $display("FAIL rstw_pending got=%0d want=0", exp_wr_q.size()); exp_wr_q.delete(); end
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_fetch();
    test_back_to_back();
    test_flush();
    test_io_stall();
    test_io_read();
    test_rdy_freeze();
    test_wrap();
    test_reset_midstore();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
